// File: rtl/irq_prio_ctrl_seq_if.sv
// Request/acknowledge bus of the priority interrupt controller.
// The requester side (master) drives req/en/irq_ack; the controller (slave) presents the winner.
interface irq_prio_ctrl_seq_if #(
  parameter int NUM_CH  = 9,
  parameter int NUM_GRP = 3
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_GRP*NUM_CH-1:0] req;
  logic [NUM_CH-1:0]         en;
  logic                      irq_ack;
  logic                      irq_valid;
  logic [NUM_GRP-1:0]        irq_grp;
  logic [CW-1:0]             irq_chan;
  logic                      pending_any;

  modport master (
    output req, en, irq_ack,
    input  irq_valid, irq_grp, irq_chan, pending_any
  );

  modport slave (
    input  req, en, irq_ack,
    output irq_valid, irq_grp, irq_chan, pending_any
  );
endinterface

// File: rtl/irq_prio_ctrl_seq.sv
// Clocked priority interrupt controller: edge-captured pending flags, fixed group priority,
// fixed or round-robin channel priority, one winner held until acknowledged.
module irq_prio_ctrl_seq #(
  parameter int NUM_CH  = 9,
  parameter int NUM_GRP = 3,
  parameter int RR_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  irq_prio_ctrl_seq_if.slave  bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int NB = NUM_GRP * NUM_CH;

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t             r_state, w_state_nxt;
  logic [NB-1:0]      r_pending, r_req_q;
  logic [NB-1:0]      w_rise, w_elig, w_clr, w_cur_mask, w_pend_nxt;
  logic [CW-1:0]      r_rr_ptr, w_rr_nxt;
  logic [CW-1:0]      r_chan, w_chan_nxt, w_win_chan;
  logic [NUM_GRP-1:0] r_grp, w_grp_nxt, w_win_grp;
  logic [NUM_CH-1:0]  w_sel_elig;
  logic               r_valid, w_valid_nxt, r_pany, w_any_elig;

  assign w_rise     = bus.req & ~r_req_q;
  assign w_elig     = r_pending & {NUM_GRP{bus.en}};
  assign w_any_elig = |w_elig;

  // Lowest-numbered group with an eligible channel wins.
  always_comb begin
    w_win_grp  = '0;
    w_sel_elig = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      if (|w_elig[g*NUM_CH +: NUM_CH]) begin
        w_win_grp  = NUM_GRP'(1) << g;
        w_sel_elig = w_elig[g*NUM_CH +: NUM_CH];
      end
    end
  end

  // Round-robin walks offsets k = 0.. from rr_ptr; scanning k downward leaves the smallest offset.
  always_comb begin
    w_win_chan = '0;
    if (RR_MODE == 0) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (w_sel_elig[c]) w_win_chan = CW'(c);
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_sel_elig[c] && ((int'(r_rr_ptr) + k == c) || (int'(r_rr_ptr) + k == c + NUM_CH)))
            w_win_chan = CW'(c);
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        w_cur_mask[g*NUM_CH + c] = r_grp[g] && (r_chan == CW'(c));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_grp_nxt   = r_grp;
    w_chan_nxt  = r_chan;
    w_rr_nxt    = r_rr_ptr;
    w_clr       = '0;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any_elig) begin
          w_valid_nxt = 1'b1;
          w_grp_nxt   = w_win_grp;
          w_chan_nxt  = w_win_chan;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.irq_ack) begin
          w_valid_nxt = 1'b0;
          w_clr       = w_cur_mask;
          w_state_nxt = S_IDLE;
          if (RR_MODE != 0)
            w_rr_nxt = (r_chan == CW'(NUM_CH - 1)) ? '0 : r_chan + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new rise on the bit being acked wins over the clear.
  assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;

  always_ff @(posedge clk) begin
    // req_q keeps sampling through reset so lines held high are not seen as edges on release.
    r_req_q <= bus.req;
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_valid   <= 1'b0;
      r_grp     <= '0;
      r_chan    <= '0;
      r_pany    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_valid   <= w_valid_nxt;
      r_grp     <= w_grp_nxt;
      r_chan    <= w_chan_nxt;
      r_pany    <= |w_pend_nxt;
    end
  end

  assign bus.irq_valid   = r_valid;
  assign bus.irq_grp     = r_grp;
  assign bus.irq_chan    = r_chan;
  assign bus.pending_any = r_pany;
endmodule

// File: tb/tb_irq_prio_ctrl_seq.sv
// Bench for irq_prio_ctrl_seq: fixed-priority and round-robin instances driven in parallel,
// directed scenarios plus random traffic against a cycle-level reference model.
module tb_irq_prio_ctrl_seq;
  localparam int NCH = 9;
  localparam int NGR = 3;
  localparam int NB  = NCH * NGR;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] req;
  logic [NCH-1:0] en;
  logic          ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_prio_ctrl_seq_if #(.NUM_CH(NCH), .NUM_GRP(NGR)) b0 ();
  irq_prio_ctrl_seq_if #(.NUM_CH(NCH), .NUM_GRP(NGR)) b1 ();

  assign b0.req = req;  assign b0.en = en;  assign b0.irq_ack = ack;
  assign b1.req = req;  assign b1.en = en;  assign b1.irq_ack = ack;

  irq_prio_ctrl_seq #(.NUM_CH(NCH), .NUM_GRP(NGR), .RR_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  irq_prio_ctrl_seq #(.NUM_CH(NCH), .NUM_GRP(NGR), .RR_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  // Reference model: index 0 = fixed priority, 1 = round-robin.
  logic [NB-1:0] m_pend [2];
  logic [NB-1:0] m_reqq [2];
  int            m_rr   [2];
  int            m_grp  [2];
  int            m_ch   [2];
  logic          m_v    [2];
  logic          m_pany [2];

  always @(posedge clk) begin
    logic [NB-1:0] rise, nxt;
    bit found;
    int c;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_pend[m] = '0; m_reqq[m] = req; m_rr[m] = 0;
        m_v[m] = 1'b0; m_grp[m] = 0; m_ch[m] = 0; m_pany[m] = 1'b0;
      end else begin
        rise = req & ~m_reqq[m];
        m_reqq[m] = req;
        nxt = m_pend[m];
        if (m_v[m]) begin
          if (ack) begin
            nxt[m_grp[m]*NCH + m_ch[m]] = 1'b0;
            m_v[m] = 1'b0;
            if (m == 1) m_rr[m] = (m_ch[m] + 1) % NCH;
          end
        end else begin
          found = 0;
          for (int g = 0; g < NGR; g++) begin
            for (int k = 0; k < NCH; k++) begin
              c = (m == 1) ? (m_rr[m] + k) % NCH : k;
              if (!found && m_pend[m][g*NCH + c] && en[c]) begin
                found = 1; m_grp[m] = g; m_ch[m] = c;
              end
            end
          end
          if (found) m_v[m] = 1'b1;
        end
        nxt = nxt | rise;
        m_pend[m] = nxt;
        m_pany[m] = |nxt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ack = 1'b0; en = '1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] o0, o1;
    rst = 1'b1; req = '1; en = '1; ack = 1'b0;
    tick(); tick();
    o0 = {b0.irq_valid, b0.irq_grp, b0.irq_chan, b0.pending_any};
    o1 = {b1.irq_valid, b1.irq_grp, b1.irq_chan, b1.pending_any};
    total++; if (o0 !== 9'h0) begin bad++; $display("FAIL reset_outs_fixed got=%h exp=000", o0); end
    total++; if (o1 !== 9'h0) begin bad++; $display("FAIL reset_outs_rr got=%h exp=000", o1); end
    rst = 1'b0;
    tick(); tick();
    total++; if ({b0.irq_valid, b0.pending_any} !== 2'b00)
      begin bad++; $display("FAIL release_no_pend_fixed got=%b exp=00", {b0.irq_valid, b0.pending_any}); end
    total++; if ({b1.irq_valid, b1.pending_any} !== 2'b00)
      begin bad++; $display("FAIL release_no_pend_rr got=%b exp=00", {b1.irq_valid, b1.pending_any}); end
    req = '0;
    tick();
  endtask

  task automatic test_group_prio();
    logic [7:0] exp [3];
    exp[0] = {1'b1, 3'b001, 4'd3};
    exp[1] = {1'b1, 3'b010, 4'd1};
    exp[2] = {1'b1, 3'b100, 4'd0};
    do_reset();
    req[3] = 1'b1; req[NCH+1] = 1'b1; req[2*NCH] = 1'b1;
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== exp[i])
        begin bad++; $display("FAIL grp_prio_fixed_%0d got=%h exp=%h", i, {b0.irq_valid, b0.irq_grp, b0.irq_chan}, exp[i]); end
      total++; if ({b1.irq_valid, b1.irq_grp, b1.irq_chan} !== exp[i])
        begin bad++; $display("FAIL grp_prio_rr_%0d got=%h exp=%h", i, {b1.irq_valid, b1.irq_grp, b1.irq_chan}, exp[i]); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total++; if (b0.irq_valid !== 1'b0)
        begin bad++; $display("FAIL grp_prio_idle_gap_%0d got=%b exp=0", i, b0.irq_valid); end
      tick();
    end
    total++; if ({b0.irq_valid, b0.pending_any} !== 2'b00)
      begin bad++; $display("FAIL grp_prio_drained got=%b exp=00", {b0.irq_valid, b0.pending_any}); end
  endtask

  task automatic test_fixed_prio();
    logic [7:0] exp [3];
    exp[0] = {1'b1, 3'b010, 4'd2};
    exp[1] = {1'b1, 3'b010, 4'd2};
    exp[2] = {1'b1, 3'b010, 4'd5};
    do_reset();
    req[NCH+5] = 1'b1; req[NCH+2] = 1'b1;
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== exp[i])
        begin bad++; $display("FAIL fixed_prio_%0d got=%h exp=%h", i, {b0.irq_valid, b0.irq_grp, b0.irq_chan}, exp[i]); end
      ack = 1'b1;
      if (i == 0) req[NCH+2] = 1'b1;
      tick();
      ack = 1'b0; req = '0;
      tick();
    end
    total++; if (b0.irq_valid !== 1'b0)
      begin bad++; $display("FAIL fixed_prio_done got=%b exp=0", b0.irq_valid); end
  endtask

  task automatic test_round_robin();
    int order [4];
    order[0] = 0; order[1] = 4; order[2] = 8; order[3] = 0;
    do_reset();
    req[0] = 1'b1; req[4] = 1'b1; req[8] = 1'b1;
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if ({b1.irq_valid, b1.irq_grp, b1.irq_chan} !== {1'b1, 3'b001, 4'(order[i])})
        begin bad++; $display("FAIL rr_order_%0d got=%h exp=%h", i, {b1.irq_valid, b1.irq_grp, b1.irq_chan}, {1'b1, 3'b001, 4'(order[i])}); end
      ack = 1'b1;
      req[order[i]] = 1'b1;
      tick();
      ack = 1'b0; req = '0;
      tick();
    end
  endtask

  task automatic test_mask_hold();
    do_reset();
    en = 9'h1BF;
    req[2*NCH+6] = 1'b1;
    tick();
    req = '0;
    tick(); tick();
    total++; if ({b0.irq_valid, b0.pending_any} !== 2'b01)
      begin bad++; $display("FAIL mask_blocked_fixed got=%b exp=01", {b0.irq_valid, b0.pending_any}); end
    total++; if ({b1.irq_valid, b1.pending_any} !== 2'b01)
      begin bad++; $display("FAIL mask_blocked_rr got=%b exp=01", {b1.irq_valid, b1.pending_any}); end
    en = '1;
    tick();
    total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== {1'b1, 3'b100, 4'd6})
      begin bad++; $display("FAIL mask_unblock got=%h exp=c6", {b0.irq_valid, b0.irq_grp, b0.irq_chan}); end
    en = 9'h1BF;
    req[1] = 1'b1;
    tick();
    req = '0;
    tick();
    total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== {1'b1, 3'b100, 4'd6})
      begin bad++; $display("FAIL mask_hold_fixed got=%h exp=c6", {b0.irq_valid, b0.irq_grp, b0.irq_chan}); end
    total++; if ({b1.irq_valid, b1.irq_grp, b1.irq_chan} !== {1'b1, 3'b100, 4'd6})
      begin bad++; $display("FAIL mask_hold_rr got=%h exp=c6", {b1.irq_valid, b1.irq_grp, b1.irq_chan}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== {1'b1, 3'b001, 4'd1})
      begin bad++; $display("FAIL mask_next_fixed got=%h exp=91", {b0.irq_valid, b0.irq_grp, b0.irq_chan}); end
    total++; if ({b1.irq_valid, b1.irq_grp, b1.irq_chan} !== {1'b1, 3'b001, 4'd1})
      begin bad++; $display("FAIL mask_next_rr got=%h exp=91", {b1.irq_valid, b1.irq_grp, b1.irq_chan}); end
    ack = 1'b1;
    tick();
    ack = 1'b0; en = '1;
  endtask

  task automatic test_boundary();
    do_reset();
    req[7] = 1'b1;
    tick();
    req = '0;
    tick();
    total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== {1'b1, 3'b001, 4'd7})
      begin bad++; $display("FAIL bnd_first got=%h exp=97", {b0.irq_valid, b0.irq_grp, b0.irq_chan}); end
    ack = 1'b1;
    req[7] = 1'b1;
    tick();
    ack = 1'b0; req = '0;
    total++; if ({b0.irq_valid, b0.pending_any} !== 2'b01)
      begin bad++; $display("FAIL bnd_ack_gap got=%b exp=01", {b0.irq_valid, b0.pending_any}); end
    tick();
    total++; if ({b0.irq_valid, b0.irq_grp, b0.irq_chan} !== {1'b1, 3'b001, 4'd7})
      begin bad++; $display("FAIL bnd_represent got=%h exp=97", {b0.irq_valid, b0.irq_grp, b0.irq_chan}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({b0.irq_valid, b0.pending_any} !== 2'b00)
      begin bad++; $display("FAIL bnd_rst_present got=%b exp=00", {b0.irq_valid, b0.pending_any}); end
    tick(); tick();
    total++; if ({b0.irq_valid, b0.pending_any, b1.irq_valid, b1.pending_any} !== 4'b0000)
      begin bad++; $display("FAIL bnd_rst_cleared got=%b exp=0000", {b0.irq_valid, b0.pending_any, b1.irq_valid, b1.pending_any}); end
  endtask

  task automatic test_random();
    logic          ov [2], op [2];
    logic [2:0]    og [2];
    logic [3:0]    oc [2];
    logic [NB-1:0] flip;
    logic [NCH-1:0] mask;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      flip = NB'($urandom & $urandom & $urandom);
      mask = NCH'($urandom & $urandom & $urandom);
      req  = req ^ flip;
      en   = ~mask;
      ack  = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 99) == 0);
      tick();
      ov[0] = b0.irq_valid; op[0] = b0.pending_any; og[0] = b0.irq_grp; oc[0] = b0.irq_chan;
      ov[1] = b1.irq_valid; op[1] = b1.pending_any; og[1] = b1.irq_grp; oc[1] = b1.irq_chan;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (ov[m] !== m_v[m] || op[m] !== m_pany[m]) begin
          bad++;
          $display("FAIL rand_vld_pany dut%0d cyc=%0d got=%b%b exp=%b%b", m, cyc, ov[m], op[m], m_v[m], m_pany[m]);
        end
        if (m_v[m]) begin
          total++;
          if (og[m] !== 3'(1 << m_grp[m]) || oc[m] !== 4'(m_ch[m])) begin
            bad++;
            $display("FAIL rand_winner dut%0d cyc=%0d got=%b/%0d exp=%b/%0d", m, cyc, og[m], oc[m], 3'(1 << m_grp[m]), m_ch[m]);
          end
        end
      end
    end
    rst = 1'b0; ack = 1'b0; req = '0; en = '1;
  endtask

  initial begin
    rst = 1'b1; req = '1; en = '1; ack = 1'b0;
    test_reset();
    test_group_prio();
    test_fixed_prio();
    test_round_robin();
    test_mask_hold();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
